// File: rtl/clock_pkg.sv
// Shared constants for the millennium clock: select codes, year range,
// month and weekday names, and the Gregorian leap-year rule.
package clock_pkg;

  localparam logic [2:0] SEL_DAY   = 3'b011;
  localparam logic [2:0] SEL_MONTH = 3'b100;
  localparam logic [2:0] SEL_YEAR  = 3'b101;

  localparam int YEAR_MIN = 2001;
  localparam int YEAR_MAX = 3000;

  typedef enum logic [3:0] {
    MON_JAN = 4'd1,  MON_FEB = 4'd2,  MON_MAR = 4'd3,  MON_APR = 4'd4,
    MON_MAY = 4'd5,  MON_JUN = 4'd6,  MON_JUL = 4'd7,  MON_AUG = 4'd8,
    MON_SEP = 4'd9,  MON_OCT = 4'd10, MON_NOV = 4'd11, MON_DEC = 4'd12
  } month_e;

  typedef enum logic [2:0] {
    WD_SUN = 3'd0, WD_MON = 3'd1, WD_TUE = 3'd2, WD_WED = 3'd3,
    WD_THU = 3'd4, WD_FRI = 3'd5, WD_SAT = 3'd6
  } weekday_e;

  // What the date register does on a given edge, in priority order below reset.
  typedef enum logic [2:0] {
    ACT_HOLD      = 3'd0,
    ACT_ADJ_DAY   = 3'd1,
    ACT_ADJ_MONTH = 3'd2,
    ACT_COUNT     = 3'd3,
    ACT_CLAMP     = 3'd4
  } date_action_e;

  function automatic logic is_leap(input logic [11:0] year);
    int y;
    y = int'(year);
    return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
  endfunction

endpackage

// File: rtl/date_day_month_dim.sv
// days_in_month: combinational month length, including Gregorian February.
module days_in_month
  import clock_pkg::*;
(
  input  logic [3:0]  month_bin,
  input  logic [11:0] year_bin,
  output logic [4:0]  dim
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    dim = 5'd31;
    case (month_bin)
      MON_APR, MON_JUN, MON_SEP, MON_NOV: dim = 5'd30;
      MON_FEB: dim = is_leap(year_bin) ? 5'd29 : 5'd28;
      default: dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_day_month.sv
// Day-of-month / month counter feeding the year counter.
// Optional weekday output enabled by defining DATE_WEEKDAY_EN.
module date_day_month
  import clock_pkg::*;
#(
  parameter logic [2:0] SELECT_DAY   = SEL_DAY,
  parameter logic [2:0] SELECT_MONTH = SEL_MONTH
) (
  input  logic        clk_1Hz,
  input  logic        rst,
  input  logic        en_1,
  input  logic        up,
  input  logic        down,
  input  logic [2:0]  select_item,
  input  logic        carry_in,
  input  logic [11:0] year_bin,
  output logic [4:0]  day_bin,
  output logic [3:0]  month_bin,
`ifdef DATE_WEEKDAY_EN
  output logic [2:0]  weekday,
`endif
  output logic        carry_out
);

  logic [4:0]   dim_cur;
  logic [4:0]   dim_adj;
  logic [3:0]   month_adj;
  logic [4:0]   day_nxt;
  logic [3:0]   month_nxt;
  logic         sel_day;
  logic         sel_month;
  logic         step_up;
  logic         step_dn;
  logic         count_event;
  date_action_e action;

  days_in_month u_dim_cur (
    .month_bin (month_bin),
    .year_bin  (year_bin),
    .dim       (dim_cur)
  );

  // Length of the month we would land on after a month adjust, for the clamp.
  days_in_month u_dim_adj (
    .month_bin (month_adj),
    .year_bin  (year_bin),
    .dim       (dim_adj)
  );

  assign sel_day     = (select_item == SELECT_DAY);
  assign sel_month   = (select_item == SELECT_MONTH);
  assign step_up     = up;
  assign step_dn     = down & ~up;
  assign count_event = en_1 & carry_in & ~sel_day & ~sel_month;
  assign carry_out   = count_event && (day_bin == dim_cur) && (month_bin == MON_DEC);

  always_comb begin
    month_adj = month_bin;
    if (step_up)
      month_adj = (month_bin == MON_DEC) ? MON_JAN : month_bin + 4'd1;
    else if (step_dn)
      month_adj = (month_bin == MON_JAN) ? MON_DEC : month_bin - 4'd1;
  end

  always_comb begin
    action = ACT_HOLD;
    if (sel_day && (step_up || step_dn))
      action = ACT_ADJ_DAY;
    else if (sel_month && (step_up || step_dn))
      action = ACT_ADJ_MONTH;
    else if (count_event)
      action = ACT_COUNT;
    else if (day_bin > dim_cur)
      action = ACT_CLAMP;
  end

  always_comb begin
    day_nxt   = day_bin;
    month_nxt = month_bin;
    case (action)
      ACT_ADJ_DAY: begin
        if (step_up)
          day_nxt = (day_bin == dim_cur) ? 5'd1 : day_bin + 5'd1;
        else
          day_nxt = (day_bin == 5'd1) ? dim_cur : day_bin - 5'd1;
      end
      ACT_ADJ_MONTH: begin
        month_nxt = month_adj;
        day_nxt   = (day_bin > dim_adj) ? dim_adj : day_bin;
      end
      ACT_COUNT: begin
        // A day past the month end (left by a year change) also rolls over.
        if (day_bin < dim_cur) begin
          day_nxt = day_bin + 5'd1;
        end else begin
          day_nxt   = 5'd1;
          month_nxt = (month_bin == MON_DEC) ? MON_JAN : month_bin + 4'd1;
        end
      end
      ACT_CLAMP: day_nxt = dim_cur;
      default: begin
        day_nxt   = day_bin;
        month_nxt = month_bin;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      day_bin   <= 5'd1;
      month_bin <= MON_JAN;
    end else begin
      day_bin   <= day_nxt;
      month_bin <= month_nxt;
    end
  end

`ifdef DATE_WEEKDAY_EN
  always_ff @(posedge clk_1Hz) begin
    if (rst)
      weekday <= WD_MON;
    else if (count_event)
      weekday <= (weekday == WD_SAT) ? WD_SUN : weekday + 3'd1;
  end
`endif

endmodule
